// File: rtl/aurora_201_rx_deframer_if.sv
// Framed 32-bit word stream from the deframer FIFO to user logic (valid/ready).
interface aurora_201_rx_deframer_if;
    logic [0:31] M_DATA;
    logic        M_SOF;
    logic        M_EOF;
    logic        M_ERR;
    logic        M_VALID;
    logic        M_READY;

    modport master (output M_DATA, M_SOF, M_EOF, M_ERR, M_VALID, input M_READY);
    modport slave  (input M_DATA, M_SOF, M_EOF, M_ERR, M_VALID, output M_READY);
endinterface

// File: rtl/aurora_201_rx_deframer.sv
// Aurora 201 RX deframer: header hunt, halfword pairing, per-frame space reservation
// and a first-word-fall-through FIFO toward a valid/ready consumer.
module aurora_201_rx_deframer #(
    parameter int         FIFO_AW   = 9,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                      USER_CLK,
    input  logic                      RESET_N,
    input  logic                      CHANNEL_UP,
    input  logic [0:15]               RX_D,
    input  logic                      RX_SRC_RDY,
    aurora_201_rx_deframer_if.master  m,
    output logic                      FRAME_DROP,
    output logic                      HDR_ERR,
    output logic [FIFO_AW:0]          FIFO_LEVEL
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, HI, LO, DISCARD} state_t;
    typedef struct packed {
        logic        err;
        logic        eof;
        logic        sof;
        logic [0:31] data;
    } entry_t;

    state_t      state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic [0:15] hi_q, hi_d;
    logic [8:0]  disc_q, disc_d;
    logic        drop_d, herr_d;
    logic        wr_en;
    entry_t      wr_entry;

    logic [7:0]         hdr_sync, hdr_len;
    logic [FIFO_AW:0]   level_q, free;

    assign hdr_sync = RX_D[0:7];
    assign hdr_len  = RX_D[8:15];
    // Level is the pre-edge value; a same-edge read is deliberately not credited.
    assign free     = (FIFO_AW+1)'(DEPTH) - level_q;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        first_d  = first_q;
        hi_d     = hi_q;
        disc_d   = disc_q;
        drop_d   = 1'b0;
        herr_d   = 1'b0;
        wr_en    = 1'b0;
        wr_entry = '0;
        if (!CHANNEL_UP) begin
            // Abort marker only if the consumer already saw part of this frame.
            if ((state_q == HI || state_q == LO) && !first_q) begin
                wr_en        = 1'b1;
                wr_entry.eof = 1'b1;
                wr_entry.err = 1'b1;
            end
            state_d = IDLE;
        end else if (RX_SRC_RDY) begin
            unique case (state_q)
                IDLE: begin
                    if (hdr_sync == SYNC_BYTE && hdr_len != 8'd0) begin
                        if (free >= (FIFO_AW+1)'(hdr_len)) begin
                            rem_d   = hdr_len;
                            first_d = 1'b1;
                            state_d = HI;
                        end else begin
                            drop_d  = 1'b1;
                            disc_d  = {hdr_len, 1'b0};
                            state_d = DISCARD;
                        end
                    end else begin
                        herr_d = 1'b1;
                    end
                end
                HI: begin
                    hi_d    = RX_D;
                    state_d = LO;
                end
                LO: begin
                    wr_en         = 1'b1;
                    wr_entry.data = {hi_q, RX_D};
                    wr_entry.sof  = first_q;
                    wr_entry.eof  = (rem_q == 8'd1);
                    first_d       = 1'b0;
                    rem_d         = rem_q - 8'd1;
                    state_d       = (rem_q == 8'd1) ? IDLE : HI;
                end
                DISCARD: begin
                    disc_d  = disc_q - 9'd1;
                    state_d = (disc_q == 9'd1) ? IDLE : DISCARD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            first_q    <= 1'b0;
            hi_q       <= '0;
            disc_q     <= '0;
            FRAME_DROP <= 1'b0;
            HDR_ERR    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            hi_q       <= hi_d;
            disc_q     <= disc_d;
            FRAME_DROP <= drop_d;
            HDR_ERR    <= herr_d;
        end
    end

    // FIFO: storage array plus one output register; level counts both.
    entry_t             mem [DEPTH];
    entry_t             out_q;
    logic               out_vld_q;
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic               pop, load;

    assign pop  = out_vld_q && m.M_READY;
    assign load = (level_q != (FIFO_AW+1)'(out_vld_q)) && (!out_vld_q || pop);

    always_ff @(posedge USER_CLK) begin
        if (wr_en) mem[wptr_q] <= wr_entry;
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            level_q <= level_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);
            if (load) begin
                out_q     <= mem[rptr_q];
                out_vld_q <= 1'b1;
                rptr_q    <= rptr_q + 1'b1;
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET_N) assert (!(wr_en && level_q == (FIFO_AW+1)'(DEPTH)));
    end

    assign m.M_DATA    = out_q.data;
    assign m.M_SOF     = out_q.sof;
    assign m.M_EOF     = out_q.eof;
    assign m.M_ERR     = out_q.err;
    assign m.M_VALID   = out_vld_q;
    assign FIFO_LEVEL  = level_q;
endmodule
